// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: unified memory port handshake between the control FSM and memory
// master: drives mem_req (access request, held until mem_ready), mem_we (store) and
//         adr_src (0 = PC, 1 = ALU result register); samples mem_ready
// slave:  memory side of the same signals
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;
  modport master(output mem_req, mem_we, adr_src, input mem_ready);
  modport slave(input mem_req, mem_we, adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core
// clk/reset: clock, async active-high reset; mem: unified memory handshake (master)
// instr: IR contents; cmp_eq/cmp_lt/cmp_ltu: rs1 vs rs2 flags
// outputs: datapath selects/enables, branch status, retire pulse/counter, halted
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_controller_if.master mem,
  input  logic [31:0]         instr,
  input  logic                cmp_eq,
  input  logic                cmp_lt,
  input  logic                cmp_ltu,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic                branch,
  output logic                branch_taken,
  output logic                retire,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_count
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
    EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;
  state_t state, next, dispatch;
  logic [6:0] op;
  logic [2:0] f3;
  logic cond;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  // funct3[0] inverts the base condition; funct3[2:1] selects eq / lt / ltu
  assign cond = f3[0] ^ (f3[2] ? (f3[1] ? cmp_ltu : cmp_lt) : cmp_eq);
  always_comb begin
    dispatch = TRAP;
    case (op)
      7'b0000011, 7'b0100011: dispatch = MEM_ADR;
      7'b0110011: dispatch = EXEC_R;
      7'b0010011: dispatch = EXEC_I;
      7'b1100011: dispatch = (f3[2:1] == 2'b01) ? TRAP : BRANCH;
      7'b1101111: dispatch = JAL;
      7'b1100111: dispatch = JALR;
      7'b0110111: dispatch = LUI;
      7'b0010111: dispatch = AUIPC;
      default:    dispatch = TRAP;
    endcase
  end
  always_comb begin
    next = state;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op = 2'd0;
    result_src = 2'd0;
    imm_src = 3'd0;
    branch = 1'b0;
    branch_taken = 1'b0;
    retire = 1'b0;
    halted = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b = 2'd2;
        result_src = 2'd2;
        ir_write = mem.mem_ready;
        pc_write = mem.mem_ready;
        next = mem.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src = (op == 7'b1101111) ? 3'd4 : 3'd2;
        retire = (dispatch == TRAP) && !HALT_ON_ILLEGAL;
        next = retire ? FETCH : dispatch;
      end
      MEM_ADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src = {2'b00, op[5]};
        next = op[5] ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem.mem_req = 1'b1;
        mem.adr_src = 1'b1;
        next = mem.mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        result_src = 2'd1;
        retire = 1'b1;
        next = FETCH;
      end
      MEM_WRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_we = 1'b1;
        mem.adr_src = 1'b1;
        retire = mem.mem_ready;
        next = mem.mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R, EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = (state == EXEC_I) ? 2'd1 : 2'd0;
        alu_op = 2'd2;
        next = ALU_WB;
      end
      ALU_WB: begin
        retire = 1'b1;
        next = FETCH;
        // jumps reach here after rd was written; recompute the target
        // (old PC + J imm, or rs1 + I imm with bit 0 cleared by the datapath)
        if (op[2]) begin
          pc_write = 1'b1;
          alu_src_a = op[3] ? 2'd1 : 2'd2;
          alu_src_b = 2'd1;
          imm_src = op[3] ? 3'd4 : 3'd0;
          result_src = 2'd2;
        end else
          reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'd2;
        alu_op = 2'd1;
        branch = 1'b1;
        branch_taken = cond;
        pc_write = cond;
        retire = 1'b1;
        next = FETCH;
      end
      JAL, JALR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        result_src = 2'd2;
        reg_write = 1'b1;
        next = ALU_WB;
      end
      LUI, AUIPC: begin
        // LUI relies on the datapath reading x0 for the U-type rs1 field
        alu_src_a = (state == LUI) ? 2'd2 : 2'd1;
        alu_src_b = 2'd1;
        imm_src = 3'd3;
        result_src = 2'd2;
        reg_write = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      TRAP: halted = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      retire_count <= '0;
    end else begin
      state <= next;
      retire_count <= retire_count + RETIRE_W'(retire);
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] instr2 = 32'h0;
  logic cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic ir_write, pc_write, reg_write, branch, branch_taken, retire, halted;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [31:0] retire_count;
  logic ir_write2, pc_write2, reg_write2, branch2, branch_taken2, retire2, halted2;
  logic [1:0] alu_src_a2, alu_src_b2, alu_op2, result_src2;
  logic [2:0] imm_src2;
  logic [3:0] retire_count2;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_controller_if m();
  multicycle_controller_if m2();
  assign m.mem_ready = mem_ready;
  assign m2.mem_ready = 1'b1;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .mem(m), .instr(instr),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .branch(branch),
    .branch_taken(branch_taken), .retire(retire), .halted(halted),
    .retire_count(retire_count)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .RETIRE_W(4)) dut2 (
    .clk(clk), .reset(reset), .mem(m2), .instr(instr2),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .ir_write(ir_write2), .pc_write(pc_write2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .result_src(result_src2), .imm_src(imm_src2), .branch(branch2),
    .branch_taken(branch_taken2), .retire(retire2), .halted(halted2),
    .retire_count(retire_count2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // runs one instruction from FETCH; wf/wm are wait cycles for fetch / data access
  task automatic run(input logic [31:0] ins, input int wf, input int wm,
                     output int cyc, output int irw, output int regw,
                     output int pcw, output int wec, output int reqc);
    int k;
    bit fetched;
    k = 0;
    fetched = 0;
    cyc = 0; irw = 0; regw = 0; pcw = 0; wec = 0; reqc = 0;
    instr = ins;
    for (int i = 0; i < 30; i++) begin
      cyc++;
      mem_ready = (k >= (fetched ? wm : wf));
      #1;
      irw += int'(ir_write);
      regw += int'(reg_write);
      pcw += int'(pc_write);
      wec += int'(m.mem_we);
      reqc += int'(m.mem_req);
      if (m.mem_req && mem_ready) begin
        k = 0;
        fetched = 1;
      end else if (m.mem_req)
        k++;
      if (retire) break;
      tick;
    end
    tick;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (m.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", m.mem_req); end
    checks++; if ({ir_write, pc_write, reg_write, retire, halted, branch} !== 6'b0) begin fails++; $display("FAIL reset_enables got %b want 000000", {ir_write, pc_write, reg_write, retire, halted, branch}); end
    checks++; if (retire_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", retire_count); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (m.mem_req !== 1'b0) begin fails++; $display("FAIL idle_mem_req got %b want 0", m.mem_req); end
    tick;
    checks++; if (m.mem_req !== 1'b1) begin fails++; $display("FAIL first_fetch_req got %b want 1", m.mem_req); end
  endtask

  task automatic test_alu;
    int cyc, irw, regw, pcw, wec, reqc;
    instr = 32'h00500093;
    mem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_write, m.adr_src, alu_src_b, result_src} !== 7'b1101010) begin fails++; $display("FAIL fetch_outputs got %b want 1101010", {ir_write, pc_write, m.adr_src, alu_src_b, result_src}); end
    tick;
    checks++; if ({alu_src_a, alu_src_b, imm_src, m.mem_req} !== 8'b01010100) begin fails++; $display("FAIL decode_outputs got %b want 01010100", {alu_src_a, alu_src_b, imm_src, m.mem_req}); end
    tick;
    checks++; if ({alu_src_a, alu_src_b, alu_op, reg_write} !== 7'b1001100) begin fails++; $display("FAIL exec_i_outputs got %b want 1001100", {alu_src_a, alu_src_b, alu_op, reg_write}); end
    tick;
    checks++; if ({reg_write, result_src, retire, pc_write} !== 5'b10010) begin fails++; $display("FAIL alu_wb_outputs got %b want 10010", {reg_write, result_src, retire, pc_write}); end
    tick;
    run(32'h00108133, 0, 0, cyc, irw, regw, pcw, wec, reqc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL add_cycles got %0d want 4", cyc); end
    checks++; if (regw !== 1) begin fails++; $display("FAIL add_reg_write got %0d want 1", regw); end
    checks++; if (retire_count !== 32'd2) begin fails++; $display("FAIL alu_retire_count got %0d want 2", retire_count); end
  endtask

  task automatic test_reset_mid_fetch;
    mem_ready = 1'b1;
    #1;
    checks++; if (ir_write !== 1'b1) begin fails++; $display("FAIL pre_reset_ir_write got %b want 1", ir_write); end
    reset = 1'b1;
    #1;
    checks++; if ({m.mem_req, ir_write, pc_write} !== 3'b000) begin fails++; $display("FAIL async_reset_outputs got %b want 000", {m.mem_req, ir_write, pc_write}); end
    checks++; if (retire_count !== 32'd0) begin fails++; $display("FAIL async_reset_count got %0d want 0", retire_count); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (m.mem_req !== 1'b0) begin fails++; $display("FAIL post_release_idle got %b want 0", m.mem_req); end
    tick;
    checks++; if (m.mem_req !== 1'b1) begin fails++; $display("FAIL post_release_fetch got %b want 1", m.mem_req); end
  endtask

  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [3:0] br_exp [6] = '{4'b0001, 4'b1110, 4'b1010, 4'b0101, 4'b1100, 4'b0011};
  logic [2:0] br_flags [4] = '{3'b100, 3'b010, 3'b001, 3'b011};

  task automatic test_branch;
    logic [3:0] e;
    for (int i = 0; i < 6; i++) begin
      e = br_exp[i];
      for (int j = 0; j < 4; j++) begin
        instr = {17'd0, br_f3[i], 5'd0, 7'b1100011};
        {cmp_eq, cmp_lt, cmp_ltu} = br_flags[j];
        mem_ready = 1'b1;
        tick;
        tick;
        checks++; if ({branch, branch_taken, pc_write, retire, alu_op} !== {1'b1, e[j], e[j], 1'b1, 2'd1}) begin fails++; $display("FAIL branch_f3_%0d_flags_%b got %b want %b", br_f3[i], br_flags[j], {branch, branch_taken, pc_write, retire, alu_op}, {1'b1, e[j], e[j], 1'b1, 2'd1}); end
        tick;
      end
    end
    {cmp_eq, cmp_lt, cmp_ltu} = 3'b000;
  endtask

  logic [31:0] t_ins [11] = '{32'h00002083, 32'h00002083, 32'h00102023, 32'h00102023, 32'h00108133,
                              32'h00000063, 32'h000010B7, 32'h00001097, 32'h0000006F, 32'h00008067, 32'h00500093};
  int t_wf [11]   = '{0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 2};
  int t_wm [11]   = '{0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0};
  int t_cyc [11]  = '{5, 11, 4, 6, 5, 3, 3, 3, 4, 4, 6};
  int t_regw [11] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
  int t_pcw [11]  = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 1};
  int t_wec [11]  = '{0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0};
  int t_reqc [11] = '{2, 8, 2, 4, 2, 1, 1, 1, 1, 1, 3};

  task automatic test_timing;
    int cyc, irw, regw, pcw, wec, reqc;
    for (int i = 0; i < 11; i++) begin
      run(t_ins[i], t_wf[i], t_wm[i], cyc, irw, regw, pcw, wec, reqc);
      checks++; if ({cyc, irw, regw, pcw, wec, reqc} !== {t_cyc[i], 32'd1, t_regw[i], t_pcw[i], t_wec[i], t_reqc[i]}) begin fails++; $display("FAIL timing_%0d_%h cyc/irw/regw/pcw/wec/reqc got %0d/%0d/%0d/%0d/%0d/%0d want %0d/1/%0d/%0d/%0d/%0d", i, t_ins[i], cyc, irw, regw, pcw, wec, reqc, t_cyc[i], t_regw[i], t_pcw[i], t_wec[i], t_reqc[i]); end
    end
  endtask

  task automatic test_trap;
    logic [31:0] rc;
    int pulses;
    instr = 32'h0000007F;
    mem_ready = 1'b1;
    tick;
    checks++; if (retire !== 1'b0) begin fails++; $display("FAIL illegal_decode_retire got %b want 0", retire); end
    tick;
    checks++; if ({halted, m.mem_req, pc_write, reg_write} !== 4'b1000) begin fails++; $display("FAIL trap_outputs got %b want 1000", {halted, m.mem_req, pc_write, reg_write}); end
    rc = retire_count;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      pulses += int'(retire);
    end
    checks++; if (pulses !== 0 || halted !== 1'b1) begin fails++; $display("FAIL trap_stays pulses/halted got %0d/%b want 0/1", pulses, halted); end
    checks++; if (retire_count !== rc) begin fails++; $display("FAIL trap_count got %0d want %0d", retire_count, rc); end
    reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL trap_reset got %b want 0", halted); end
    tick;
    reset = 1'b0;
    tick;
    instr = 32'h00002063;
    tick;
    tick;
    checks++; if ({halted, retire} !== 2'b10) begin fails++; $display("FAIL branch_f3_010_trap got %b want 10", {halted, retire}); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_wrap_and_nop;
    int n;
    reset = 1'b1;
    instr2 = 32'h00500093;
    tick;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 17; i++) begin
      tick;
      if (retire2) n++;
    end
    checks++; if (n !== 17) begin fails++; $display("FAIL wrap_retires got %0d want 17", n); end
    checks++; if (retire_count2 !== 4'd0) begin fails++; $display("FAIL wrap_count_16 got %0d want 0", retire_count2); end
    tick;
    checks++; if (retire_count2 !== 4'd1) begin fails++; $display("FAIL wrap_count_17 got %0d want 1", retire_count2); end
    instr2 = 32'h0000007F;
    tick;
    checks++; if ({retire2, halted2} !== 2'b10) begin fails++; $display("FAIL nop_illegal_retire got %b want 10", {retire2, halted2}); end
    tick;
    checks++; if ({m2.mem_req, halted2} !== 2'b10) begin fails++; $display("FAIL nop_back_to_fetch got %b want 10", {m2.mem_req, halted2}); end
    checks++; if (retire_count2 !== 4'd2) begin fails++; $display("FAIL nop_count got %0d want 2", retire_count2); end
  endtask

  initial begin
    instr2 = 32'h00500093;
    test_reset;
    test_alu;
    test_reset_mid_fetch;
    test_branch;
    test_timing;
    test_trap;
    test_wrap_and_nop;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
